// File: rtl/pc_pkg.sv
// Shared types and default parameters for the program-counter sequencer.
// Imported by pc_next_calc and pc_sequencer.
package pc_pkg;

   localparam int unsigned PC_WIDTH_DEF     = 8;
   localparam int unsigned RESET_PC_DEF     = 0;
   localparam int unsigned FLUSH_CYCLES_DEF = 2;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_HALT  = 2'd2
   } pc_state_e;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selection: halt > absolute jump > relative branch > increment.
// Purely combinational; the caller decides when requests are sampled.
module pc_next_calc
   import pc_pkg::*;
#(
   parameter int unsigned PC_WIDTH = PC_WIDTH_DEF
) (
   input  logic                sample_en,
   input  logic                halt,
   input  logic                jmp_en,
   input  logic                jump,
   input  logic [PC_WIDTH-1:0] pc,
   input  logic [PC_WIDTH-1:0] br_offset,
   input  logic [PC_WIDTH-1:0] jmp_target,
   output logic [PC_WIDTH-1:0] next_pc,
   output logic                halt_req,
   output logic                redirect
);

   always_comb begin
      next_pc  = pc;
      halt_req = 1'b0;
      redirect = 1'b0;
      if (sample_en) begin
         if (halt) begin
            halt_req = 1'b1;
         end else if (jmp_en) begin
            next_pc  = jmp_target;
            redirect = 1'b1;
         end else if (jump) begin
            // two's-complement offset wraps naturally at PC_WIDTH
            next_pc  = pc + br_offset;
            redirect = 1'b1;
         end else begin
            next_pc  = pc + PC_WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: RUN / FLUSH / HALT control with redirect bubbles
// and a saturating redirect counter.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int unsigned PC_WIDTH     = PC_WIDTH_DEF,
   parameter int unsigned RESET_PC     = RESET_PC_DEF,
   parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                stall,
   input  logic                jump,
   input  logic [PC_WIDTH-1:0] br_offset,
   input  logic                jmp_en,
   input  logic [PC_WIDTH-1:0] jmp_target,
   input  logic                halt,
   output logic [PC_WIDTH-1:0] pc,
   output logic                pc_valid,
   output logic                flush,
   output logic                halted,
   output logic [7:0]          redirect_count
);

   pc_state_e           state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [2:0]          cnt_q, cnt_d;
   logic [7:0]          rcnt_q, rcnt_d;

   logic [PC_WIDTH-1:0] next_pc;
   logic                halt_req;
   logic                redirect;
   logic                sample_en;

   assign sample_en = (state_q == ST_RUN) && !stall;

   pc_next_calc #(
      .PC_WIDTH (PC_WIDTH)
   ) u_next (
      .sample_en  (sample_en),
      .halt       (halt),
      .jmp_en     (jmp_en),
      .jump       (jump),
      .pc         (pc_q),
      .br_offset  (br_offset),
      .jmp_target (jmp_target),
      .next_pc    (next_pc),
      .halt_req   (halt_req),
      .redirect   (redirect)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      rcnt_d  = rcnt_q;
      if (!stall) begin
         unique case (state_q)
            ST_RUN: begin
               pc_d = next_pc;
               if (halt_req) begin
                  state_d = ST_HALT;
               end else if (redirect) begin
                  state_d = ST_FLUSH;
                  cnt_d   = 3'(FLUSH_CYCLES);
                  if (rcnt_q != 8'hFF) begin
                     rcnt_d = rcnt_q + 8'd1;
                  end
               end
            end
            ST_FLUSH: begin
               cnt_d = cnt_q - 3'd1;
               if (cnt_q == 3'd1) begin
                  state_d = ST_RUN;
               end
            end
            ST_HALT: begin
               state_d = ST_HALT;
            end
            default: begin
               state_d = ST_RUN;
               cnt_d   = 3'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_RUN;
         pc_q    <= PC_WIDTH'(RESET_PC);
         cnt_q   <= 3'd0;
         rcnt_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         rcnt_q  <= rcnt_d;
      end
   end

   assign pc             = pc_q;
   assign pc_valid       = (state_q == ST_RUN);
   assign flush          = (state_q == ST_FLUSH);
   assign halted         = (state_q == ST_HALT);
   assign redirect_count = rcnt_q;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter PC_WIDTH, default 8, program-counter width in bits.
REQ-002 The block SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 The block SHALL have parameter FLUSH_CYCLES, default 2, bubble cycles after any redirect, legal range 1..7.
REQ-004 The block SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-006 The block SHALL have port stall, input, 1, freezes PC and all state while high.
REQ-007 The block SHALL have port jump, input, 1, taken-branch request from br_control_unit.
REQ-008 The block SHALL have port br_offset, input, PC_WIDTH, two's-complement branch displacement.
REQ-009 The block SHALL have port jmp_en, input, 1, unconditional absolute jump request.
REQ-010 The block SHALL have port jmp_target, input, PC_WIDTH, absolute jump address.
REQ-011 The block SHALL have port halt, input, 1, stop request.
REQ-012 The block SHALL have port pc, output, PC_WIDTH, current fetch address (registered).
REQ-013 The block SHALL have port pc_valid, output, 1, high only in RUN state.
REQ-014 The block SHALL have port flush, output, 1, high only in FLUSH state; downstream squashes its stages.
REQ-015 The block SHALL have port halted, output, 1, high only in HALT state.
REQ-016 The block SHALL have port redirect_count, output, 8, number of taken redirects, saturating.

Function
REQ-017 The FSM SHALL have exactly three states: RUN, FLUSH, HALT.
REQ-018 Inputs jump, jmp_en, halt SHALL be sampled only in RUN with stall low; in FLUSH and HALT they SHALL be ignored.
REQ-019 Priority in RUN SHALL be halt > jmp_en > jump > sequential increment.
REQ-020 RUN, halt high: pc holds, next state HALT.
REQ-021 RUN, jmp_en high: pc <= jmp_target, flush counter <= FLUSH_CYCLES, next state FLUSH, redirect_count += 1.
REQ-022 RUN, jump high (jmp_en low): pc <= pc + br_offset, modulo 2^PC_WIDTH; counter and count as in REQ-021; next state FLUSH.
REQ-023 RUN, no request: pc <= pc + 1, modulo 2^PC_WIDTH (all-ones wraps to 0).
REQ-024 In FLUSH with stall low, pc SHALL hold and the counter SHALL decrement; when the counter is 1, the next state SHALL be RUN, so flush stays high exactly FLUSH_CYCLES unstalled cycles.
REQ-025 With stall high, pc, state, flush counter and redirect_count SHALL hold in every state.
REQ-026 HALT SHALL be exited only by reset; pc frozen.
REQ-027 redirect_count SHALL saturate at 255 and never wrap.
REQ-028 Redirect latency SHALL be one cycle: target appears on pc the cycle after the request is sampled.

Reset
REQ-029 With reset_n low at a rising edge: pc=RESET_PC, state=RUN, flush counter=0, redirect_count=0; hence pc_valid=1, flush=0, halted=0.
REQ-030 Reset SHALL override stall and every request, including mid-FLUSH and in HALT.

Structure
REQ-031 A shared package pc_pkg SHALL hold the state enumeration and the default values of PC_WIDTH, RESET_PC and FLUSH_CYCLES.
REQ-032 Next-PC selection and adder logic SHALL live in sub-module pc_next_calc (combinational); the FSM and registers stay in pc_sequencer.

Verification
REQ-033 Reset then 4 idle cycles -> pc 0,1,2,3,4; pc_valid=1 throughout.
REQ-034 pc=0x10, jump=1, br_offset=0xFC -> pc=0x0C next cycle; flush=1 for 2 cycles; then pc_valid=1; pc=0x0D one cycle later; redirect_count=1.
REQ-035 pc=0xFF idle -> pc=0x00; pc=0xF0, jump with br_offset=0x20 -> pc=0x10.
REQ-036 jmp_en=1 with jmp_target=0x40, jump=1 and br_offset=0x05 in the same cycle -> pc=0x40.
REQ-037 halt=1 together with jmp_en=1 -> halted=1, pc unchanged; requests ignored; reset -> pc=0, RUN.
REQ-038 Covers two cases:
- Stall held 3 cycles during FLUSH -> flush length extended to 5 cycles total.
- Reset in the first FLUSH cycle -> pc=0, flush=0 next cycle.

Also covers 300 redirects -> redirect_count=255.
